uart_cfg: RTL

Parametrised full-duplex UART; successor to the fixed 8N1 uart core. Adds configurable bit timing, data width, parity, stop bits, mid-bit RX sampling with start-bit validation, framing/parity/overflow error flags and a show-ahead RX FIFO. Sits between SoC peripheral logic and the board serial pins on the single system clock.

---
 rtl/uart_cfg_if.sv | 30 +++
 rtl/uart_cfg.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cfg_if.sv
// Parallel-side bus of the configurable UART: the transmit request,
// the receive FIFO and the sticky error flags.
interface uart_cfg_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data_i;
    logic                 tx_en_i;
    logic                 tx_busy_o;
    logic                 rx_ready_o;
    logic [DATA_BITS-1:0] rx_data_o;
    logic                 rx_rd_i;
    logic                 rx_frame_err_o;
    logic                 rx_parity_err_o;
    logic                 rx_overflow_o;
    logic                 rx_err_clr_i;

    // The peripheral logic that drives the UART.
    modport master (
        output tx_data_i, tx_en_i, rx_rd_i, rx_err_clr_i,
        input  tx_busy_o, rx_ready_o, rx_data_o,
               rx_frame_err_o, rx_parity_err_o, rx_overflow_o
    );

    // The UART itself.
    modport slave (
        input  tx_data_i, tx_en_i, rx_rd_i, rx_err_clr_i,
        output tx_busy_o, rx_ready_o, rx_data_o,
               rx_frame_err_o, rx_parity_err_o, rx_overflow_o
    );
endinterface

// File: rtl/uart_cfg.sv
// Configurable full-duplex UART: independent TX and RX state machines,
// mid-bit RX sampling with false-start rejection, sticky error flags and
// a show-ahead RX FIFO.
module uart_cfg #(
    parameter int CLKS_PER_BIT  = 174,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic       tx_o,
    uart_cfg_if.slave  bus
);
    localparam int CW = $clog2(STOP_BITS * CLKS_PER_BIT + 1);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(RX_FIFO_DEPTH);

    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_BIT  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL_BIT  = CW'(CLKS_PER_BIT);
    localparam logic [BW-1:0] BIT_ZERO  = {BW{1'b0}};
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(RX_FIFO_DEPTH);
    localparam bit            PAR_EN    = (PARITY != 0);
    localparam bit            PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_e;

    // Parity bit to transmit / expect for a payload word.
    function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
        return (^d) ^ PAR_ODD;
    endfunction

    // ---------------- transmitter ----------------
    state_e               tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_q, tx_d;
    logic                 tx_busy_q, tx_busy_d;

    // TX next state: the line value is registered so tx_o changes one cycle after the decision.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        tx_busy_d  = tx_busy_q;
        case (tx_state_q)
            ST_IDLE: begin
                if (bus.tx_en_i) begin
                    tx_state_d = ST_START;
                    tx_shift_d = bus.tx_data_i;
                    tx_par_d   = calc_parity(bus.tx_data_i);
                    tx_cnt_d   = CNT_ZERO;
                    tx_bit_d   = BIT_ZERO;
                    tx_d       = 1'b0;
                    tx_busy_d  = 1'b1;
                end else begin
                    tx_d      = 1'b1;
                    tx_busy_d = 1'b0;
                end
            end
            ST_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = CNT_ZERO;
                    tx_state_d = ST_DATA;
                    tx_d       = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = CNT_ZERO;
                    if (tx_bit_q == DATA_LAST) begin
                        if (PAR_EN) begin
                            tx_state_d = ST_PARITY;
                            tx_d       = tx_par_q;
                        end else begin
                            tx_state_d = ST_STOP;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        tx_bit_d   = tx_bit_q + BIT_ONE;
                        tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            ST_PARITY: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = CNT_ZERO;
                    tx_state_d = ST_STOP;
                    tx_d       = 1'b1;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == STOP_LAST) begin
                    tx_cnt_d   = CNT_ZERO;
                    tx_state_d = ST_IDLE;
                    tx_d       = 1'b1;
                    tx_busy_d  = 1'b0;
                end else begin
                    tx_cnt_d = tx_cnt_q + CNT_ONE;
                end
            end
            default: begin
                tx_state_d = ST_IDLE;
                tx_cnt_d   = CNT_ZERO;
                tx_d       = 1'b1;
                tx_busy_d  = 1'b0;
            end
        endcase
    end

    // TX state register; reset forces the line idle-high immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= CNT_ZERO;
            tx_bit_q   <= BIT_ZERO;
            tx_shift_q <= {DATA_BITS{1'b0}};
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            tx_busy_q  <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    // ---------------- receiver ----------------
    logic                 rx_s1_q, rx_s2_q, rx_prev_q;
    state_e               rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]        rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_bit_q, rx_par_bit_d;
    logic                 push_s, frame_err_set_s, parity_err_set_s;

    // RX next state: start is validated at half a bit, later bits sampled one bit apart.
    always_comb begin
        rx_state_d       = rx_state_q;
        rx_cnt_d         = rx_cnt_q;
        rx_bit_d         = rx_bit_q;
        rx_shift_d       = rx_shift_q;
        rx_par_bit_d     = rx_par_bit_q;
        push_s           = 1'b0;
        frame_err_set_s  = 1'b0;
        parity_err_set_s = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = ST_START;
                    rx_cnt_d   = CNT_ONE;
                end else begin
                    rx_cnt_d = CNT_ZERO;
                end
            end
            ST_START: begin
                if (rx_cnt_q == HALF_BIT) begin
                    if (rx_s2_q) begin
                        rx_state_d = ST_IDLE;
                        rx_cnt_d   = CNT_ZERO;
                    end else begin
                        rx_state_d = ST_DATA;
                        rx_cnt_d   = CNT_ONE;
                        rx_bit_d   = BIT_ZERO;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == FULL_BIT) begin
                    rx_cnt_d   = CNT_ONE;
                    rx_shift_d = {rx_s2_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == DATA_LAST) begin
                        rx_state_d = PAR_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + BIT_ONE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            ST_PARITY: begin
                if (rx_cnt_q == FULL_BIT) begin
                    rx_cnt_d     = CNT_ONE;
                    rx_par_bit_d = rx_s2_q;
                    rx_state_d   = ST_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (rx_cnt_q == FULL_BIT) begin
                    rx_state_d       = ST_IDLE;
                    rx_cnt_d         = CNT_ZERO;
                    frame_err_set_s  = !rx_s2_q;
                    parity_err_set_s = PAR_EN && (rx_par_bit_q != calc_parity(rx_shift_q));
                    push_s           = rx_s2_q && !parity_err_set_s;
                end else begin
                    rx_cnt_d = rx_cnt_q + CNT_ONE;
                end
            end
            default: begin
                rx_state_d = ST_IDLE;
                rx_cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // RX synchroniser, edge-detect history and state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q      <= 1'b1;
            rx_s2_q      <= 1'b1;
            rx_prev_q    <= 1'b1;
            rx_state_q   <= ST_IDLE;
            rx_cnt_q     <= CNT_ZERO;
            rx_bit_q     <= BIT_ZERO;
            rx_shift_q   <= {DATA_BITS{1'b0}};
            rx_par_bit_q <= 1'b0;
        end else begin
            rx_s1_q      <= rx_i;
            rx_s2_q      <= rx_s1_q;
            rx_prev_q    <= rx_s2_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_par_bit_q <= rx_par_bit_d;
        end
    end

    // ---------------- RX FIFO and error flags ----------------
    logic [DATA_BITS-1:0] mem_q [RX_FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [RX_FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fill_s;
    logic                 ready_q, ready_d;
    logic [DATA_BITS-1:0] head_q, head_d;
    logic                 frame_err_q, frame_err_d, parity_err_q, parity_err_d;
    logic                 overflow_q, overflow_d;
    logic                 full_s, pop_s, wr_ok_s;

    // FIFO update: a pop frees the slot a simultaneous push into a full FIFO needs.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_s   = wr_ptr_q - rd_ptr_q;
        full_s   = (fill_s == FULL_CNT);
        pop_s    = bus.rx_rd_i && (wr_ptr_q != rd_ptr_q);
        wr_ok_s  = push_s && (!full_s || pop_s);
        if (wr_ok_s) begin
            mem_d[wr_ptr_q[AW-1:0]] = rx_shift_q;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        ready_d = (wr_ptr_d != rd_ptr_d);
        head_d  = mem_d[rd_ptr_d[AW-1:0]];
        frame_err_d  = frame_err_set_s  ? 1'b1 : (bus.rx_err_clr_i ? 1'b0 : frame_err_q);
        parity_err_d = parity_err_set_s ? 1'b1 : (bus.rx_err_clr_i ? 1'b0 : parity_err_q);
        overflow_d   = (push_s && full_s && !pop_s) ? 1'b1
                     : (bus.rx_err_clr_i ? 1'b0 : overflow_q);
    end

    // FIFO storage, pointers, registered head/ready and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RX_FIFO_DEPTH; i++) begin
                mem_q[i] <= {DATA_BITS{1'b0}};
            end
            wr_ptr_q     <= {(AW+1){1'b0}};
            rd_ptr_q     <= {(AW+1){1'b0}};
            ready_q      <= 1'b0;
            head_q       <= {DATA_BITS{1'b0}};
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ready_q      <= ready_d;
            head_q       <= head_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overflow_q   <= overflow_d;
        end
    end

    assign tx_o                = tx_q;
    assign bus.tx_busy_o       = tx_busy_q;
    assign bus.rx_ready_o      = ready_q;
    assign bus.rx_data_o       = head_q;
    assign bus.rx_frame_err_o  = frame_err_q;
    assign bus.rx_parity_err_o = parity_err_q;
    assign bus.rx_overflow_o   = overflow_q;
endmodule
